// File: rtl/mem_responder_if.sv
// Processor memory bus plus boot-loader stream, grouped for the memory responder.
// The master side is the processor/top level; the slave side is mem_responder.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] out;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  cpu_rst_n;
  logic                  load_done;

  modport master (
    output we, addr, data, ld_valid, ld_data,
    input  out, ld_ready, cpu_rst_n, load_done
  );

  modport slave (
    input  we, addr, data, ld_valid, ld_data,
    output out, ld_ready, cpu_rst_n, load_done
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port synchronous RAM with a built-in boot loader: holds the processor in
// reset while a LOAD_WORDS image streams in, then serves 1-cycle-latency bus traffic.
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LOAD_WORDS - 1);

  typedef enum logic {LOAD, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] out_q;
  logic                  ld_ready_q;
  logic                  cpu_rst_n_q;
  logic                  load_done_q;
  logic                  accept;
  logic                  last_word;

  assign accept    = (state == LOAD) && ld_ready_q && bus.ld_valid;
  assign last_word = (cnt == LAST_CNT);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && last_word) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Handshake and processor-reset outputs are registered from the next state, so
  // ld_ready appears one edge after reset release and cpu_rst_n rises on the final accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      ld_ready_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (accept) cnt <= last_word ? '0 : cnt + CNT_WIDTH'(1);
      ld_ready_q  <= (state_next == LOAD);
      cpu_rst_n_q <= (state_next == RUN);
      load_done_q <= (state == LOAD) && (state_next == RUN);
      if (state == RUN) out_q <= bus.we ? bus.data : mem[bus.addr];
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps contents across rst.
  always_ff @(posedge clk) begin
    if (accept)                     mem[cnt[ADDR_WIDTH-1:0]] <= bus.ld_data;
    else if (state == RUN && bus.we) mem[bus.addr]           <= bus.data;
  end

  assign bus.out       = out_q;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.load_done = load_done_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: boot load, loader stalls, read/write latency,
// asynchronous reset mid-run and mid-load, and bus isolation while loading.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus_a ();
  mem_responder_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus_b ();

  mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LOAD_WORDS(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LOAD_WORDS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_a_cycle(input logic w, input logic [5:0] a, input logic [15:0] d,
                             input logic [15:0] want, input string tag);
    logic [15:0] e;
    string       t;
    bus_a.we = w; bus_a.addr = a; bus_a.data = d;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    step();
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 32'(bus_a.out), 32'(e));
  endtask

  task automatic bus_b_read(input logic [5:0] a, input logic [15:0] want, input string tag);
    logic [15:0] e;
    string       t;
    bus_b.we = 1'b0; bus_b.addr = a; bus_b.data = '0;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    step();
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 32'(bus_b.out), 32'(e));
  endtask

  initial begin
    logic        v_pat [7];
    logic [15:0] words [4];
    int          k;
    int          ready_cycles;
    int          early_release;
    int          pulses;

    v_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    rst = 1'b1;
    bus_a.we = 1'b0; bus_a.addr = '0; bus_a.data = '0; bus_a.ld_valid = 1'b0; bus_a.ld_data = '0;
    bus_b.we = 1'b0; bus_b.addr = '0; bus_b.data = '0; bus_b.ld_valid = 1'b0; bus_b.ld_data = '0;

    // Reset values.
    step();
    check("rst_out",       32'(bus_a.out), 32'h0);
    check("rst_ld_ready",  32'(bus_a.ld_ready), 32'h0);
    check("rst_cpu_rst_n", 32'(bus_a.cpu_rst_n), 32'h0);
    check("rst_load_done", 32'(bus_a.load_done), 32'h0);
    rst = 1'b0;
    check("rel_ld_ready_low", 32'(bus_a.ld_ready), 32'h0);
    step();
    check("ld_ready_rise_a", 32'(bus_a.ld_ready), 32'h1);
    check("ld_ready_rise_b", 32'(bus_b.ld_ready), 32'h1);

    // Loader stalls on the LOAD_WORDS=4 instance.
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus_b.ld_valid = v_pat[i];
      bus_b.ld_data  = v_pat[i] ? words[k] : 16'hFFFF;
      step();
      if (v_pat[i]) k++;
      if (k < 4) begin
        check("b_hold_rst", 32'(bus_b.cpu_rst_n), 32'h0);
        check("b_ready",    32'(bus_b.ld_ready), 32'h1);
      end else begin
        check("b_release",   32'(bus_b.cpu_rst_n), 32'h1);
        check("b_load_done", 32'(bus_b.load_done), 32'h1);
      end
    end
    bus_b.ld_valid = 1'b0;
    bus_b_read(6'd0, 16'h1111, "b_rd0");
    check("b_done_pulse_end", 32'(bus_b.load_done), 32'h0);
    bus_b_read(6'd1, 16'h2222, "b_rd1");
    bus_b_read(6'd2, 16'h3333, "b_rd2");
    bus_b_read(6'd3, 16'h4444, "b_rd3");

    // Boot load of 64 words, back to back.
    ready_cycles = 0; early_release = 0; pulses = 0;
    for (int i = 0; i < 64; i++) begin
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = 16'h8000 + 16'(i);
      if (bus_a.ld_ready) ready_cycles++;
      if (bus_a.cpu_rst_n) early_release++;
      step();
      if (bus_a.load_done) pulses++;
    end
    check("boot_cpu_rst_n",   32'(bus_a.cpu_rst_n), 32'h1);
    check("boot_load_done",   32'(bus_a.load_done), 32'h1);
    check("boot_ready_cyc",   32'(ready_cycles), 32'd64);
    check("boot_early_rel",   32'(early_release), 32'd0);
    bus_a.ld_valid = 1'b0;
    step();
    if (bus_a.load_done) pulses++;
    check("boot_pulses",      32'(pulses), 32'd1);
    check("boot_ready_after", 32'(bus_a.ld_ready), 32'h0);
    check("boot_run_rst_n",   32'(bus_a.cpu_rst_n), 32'h1);

    bus_a_cycle(1'b0, 6'd0,  '0, 16'h8000, "rd_addr0");
    bus_a_cycle(1'b0, 6'd8,  '0, 16'h8008, "rd_addr8");
    bus_a_cycle(1'b0, 6'd63, '0, 16'h803F, "rd_addr63");

    // Read latency: output unchanged during the request cycle.
    bus_a.we = 1'b0; bus_a.addr = 6'd5;
    check("lat_hold", 32'(bus_a.out), 32'h803F);
    bus_a_cycle(1'b0, 6'd5, '0, 16'h8005, "lat_rd5");

    // Write-first, then stored value.
    bus_a_cycle(1'b1, 6'd3, 16'hBEEF, 16'hBEEF, "wr_first");
    bus_a_cycle(1'b0, 6'd3, '0,       16'hBEEF, "wr_stored");

    // Reset mid-run: outputs clear asynchronously.
    #2 rst = 1'b1;
    #1;
    check("mrun_out",       32'(bus_a.out), 32'h0);
    check("mrun_cpu_rst_n", 32'(bus_a.cpu_rst_n), 32'h0);
    check("mrun_ld_ready",  32'(bus_a.ld_ready), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("mrun_ready_back", 32'(bus_a.ld_ready), 32'h1);

    // Partial load of 10 words with the bus driving a write to addr 2.
    bus_a.we = 1'b1; bus_a.addr = 6'd2; bus_a.data = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = 16'h9000 + 16'(i);
      step();
      check("part_out_zero", 32'(bus_a.out), 32'h0);
    end

    // Reset mid-load.
    #2 rst = 1'b1;
    #1;
    check("mload_ld_ready",  32'(bus_a.ld_ready), 32'h0);
    check("mload_cpu_rst_n", 32'(bus_a.cpu_rst_n), 32'h0);
    bus_a.ld_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    bus_a.ld_valid = 1'b1;
    bus_a.ld_data  = 16'hC000;
    step();
    bus_a.ld_valid = 1'b0;
    step();
    check("restart_addr0", 32'(dut_a.mem[0]), 32'hC000);
    check("kept_addr1",    32'(dut_a.mem[1]), 32'h9001);
    check("iso_addr2",     32'(dut_a.mem[2]), 32'h9002);
    for (int i = 10; i < 64; i++)
      check("kept_tail", 32'(dut_a.mem[i]), 32'h8000 + 32'(i));

    // Finish the reload; the bus write stays ignored until RUN.
    for (int i = 1; i < 64; i++) begin
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = 16'hC000 + 16'(i);
      step();
      if (i == 63) bus_a.we = 1'b0;
      check("reload_out_zero", 32'(bus_a.out), 32'h0);
    end
    bus_a.ld_valid = 1'b0;
    check("reload_cpu_rst_n", 32'(bus_a.cpu_rst_n), 32'h1);
    check("reload_done",      32'(bus_a.load_done), 32'h1);
    bus_a_cycle(1'b0, 6'd2,  '0, 16'hC002, "iso_rd2");
    bus_a_cycle(1'b0, 6'd63, '0, 16'hC03F, "reload_rd63");
    bus_a_cycle(1'b0, 6'd0,  '0, 16'hC000, "reload_rd0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's single-port memory bus: a synchronous RAM that serves `we`/`addr`/`data` requests with a one-cycle registered read. A boot loader front end is built in. After reset it accepts a program image over a valid/ready stream and holds the processor in reset until the image is loaded, then releases it and serves bus traffic. It sits between the top level and the processor's `mem_*` ports.

## Interface
- `ADDR_WIDTH`, default 6: address width; the array holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 16: word width.
- `LOAD_WORDS`, default 64: number of words in the boot image, legal range 1..2^ADDR_WIDTH. Loaded into addresses 0..LOAD_WORDS-1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `we`  in  1  bus write enable from processor.
- `addr`  in  ADDR_WIDTH  bus address from processor.
- `data`  in  DATA_WIDTH  bus write data from processor.
- `out`  out  DATA_WIDTH  registered read data to processor `mem_in`.
- `ld_valid`  in  1  loader word present.
- `ld_data`  in  DATA_WIDTH  loader word.
- `ld_ready`  out  1  responder accepts a loader word this cycle.
- `cpu_rst_n`  out  1  active-low reset to processor; low while loading.
- `load_done`  out  1  one-cycle pulse on the cycle `cpu_rst_n` first rises.

## Operation
- The FSM has two states: LOAD (entered on reset) and RUN.
- LOAD:
  - `ld_ready`=1. A word is accepted when `ld_valid`&`ld_ready` at a rising edge. It is written to `mem[cnt]` and `cnt` increments.
  - `cnt` is a $clog2(2^ADDR_WIDTH)+1-bit counter.
  - When the accepted word has `cnt`==LOAD_WORDS-1, the next state is RUN and `cnt` returns to 0.
  - `ld_valid` low: no write, counter holds.
  - Bus inputs `we`/`addr`/`data` are ignored and `out` holds 0.
- RUN:
  - `ld_ready`=0 and `ld_valid` is ignored.
  - `cpu_rst_n`=1. It is registered and rises on the edge that enters RUN.
  - `load_done`=1 for exactly that first RUN cycle.
  - Each edge with `we`=1: `mem[addr]<=data` and `out<=data` (write-first).
  - Each edge with `we`=0: `out<=mem[addr]`.
- Array contents are not cleared by reset. Words at addresses ≥LOAD_WORDS keep prior contents (undefined after power-up).
- Addresses are used modulo 2^ADDR_WIDTH with no range check. All data paths are DATA_WIDTH wide with no truncation.

## Timing
- Reset values while `rst`=1 and on release: state=LOAD, `cnt`=0, `out`=0, `ld_ready`=0, `cpu_rst_n`=0, `load_done`=0.
- `ld_ready` rises on the first rising edge after `rst` falls, so the first word can be accepted one edge later.
- Load throughput is one word per cycle. Back-to-back `ld_valid` loads LOAD_WORDS words in LOAD_WORDS cycles.
- `cpu_rst_n` and `load_done` are registered. Both go high on the same edge that accepts the final word, so the processor sees reset released in the cycle after that edge.
- Read latency is 1: `addr` presented in cycle N gives `out`=mem[addr] valid throughout cycle N+1. This matches a processor that drives the address in one state and samples `mem_in` in the next.
- Write: the array is updated at the edge ending cycle N. A read of the same address in cycle N+1 returns the new value.
- Simultaneous write and read of the same address in one cycle: `out` shows the written data.
- Reset asserted mid-load or mid-run:
  - Outputs return to reset values immediately (asynchronously) and state returns to LOAD.
  - A partial load restarts at address 0.
  - The processor is re-held in reset.
  - Already-written array words are retained.
- LOAD_WORDS=1: the single accepted word moves to RUN.

## Test plan
- Boot load: reset, stream words 0x8000+i for i=0..63 with `ld_valid` held high.
  - `ld_ready` is high for 64 cycles.
  - `cpu_rst_n` rises and `load_done` pulses exactly once, on the 64th acceptance edge.
  - `ld_ready` is 0 afterwards.
  - Bus reads of addr 0, 8, 63 return 0x8000, 0x8008, 0x803F.
- Loader stalls: toggle `ld_valid` 1,0,0,1 with LOAD_WORDS=4 and data 0x1111..0x4444.
  - Only asserted cycles write, to addresses 0..3 in order.
  - `cpu_rst_n` stays 0 until the 4th word.
- Read latency: in RUN, addr=5 (holding 0x8005) with `we`=0.
  - `out` is 0x8005 one cycle later and unchanged in the request cycle.
- Write then read: `we`=1, addr=3, data=0xBEEF, then `we`=0, addr=3.
  - `out` is 0xBEEF on both following cycles (write-first, then stored).
- Reset mid-load: assert `rst` after 10 of 64 words.
  - `ld_ready` and `cpu_rst_n` go 0 asynchronously.
  - After release, the next word lands at address 0.
  - Addresses 10..63 keep their old contents.
- Load-phase bus isolation: drive `we`=1, addr=2, data=0xDEAD during LOAD.
  - After load, addr 2 holds the loader word, not 0xDEAD.
  - `out` stays 0 throughout LOAD.
